// File: rtl/usb_packet_arbiter_if.sv
// Packet bus between the trace/aux sources, the usb_packet_arbiter and usb_comm.
// The master modport is the arbiter's view; the slave modport is the surrounding logic.
interface usb_packet_arbiter_if;
    logic        trc_strobe;
    logic [1:0]  trc_type;
    logic [22:0] trc_payload;
    logic        aux_req;
    logic [1:0]  aux_type;
    logic [22:0] aux_payload;
    logic        aux_ack;
    logic        out_ready;
    logic        out_strobe;
    logic [1:0]  out_type;
    logic [22:0] out_payload;

    modport master (
        input  trc_strobe, trc_type, trc_payload,
        input  aux_req, aux_type, aux_payload,
        input  out_ready,
        output aux_ack, out_strobe, out_type, out_payload
    );

    modport slave (
        output trc_strobe, trc_type, trc_payload,
        output aux_req, aux_type, aux_payload,
        output out_ready,
        input  aux_ack, out_strobe, out_type, out_payload
    );
endinterface

// File: rtl/usb_packet_arbiter.sv
// Shares the usb_comm packet port between a buffered, never-stalled trace stream and a req/ack aux source.
// Define OVERFLOW_MARKER_EN to insert a type-11 / 23'h7FFFFF gap marker after a trace overflow.
module usb_packet_arbiter #(
    parameter int DEPTH      = 16,
    parameter int AW         = 4,
    parameter int AUX_STARVE = 16
) (
    input  logic                 mclk,
    input  logic                 reset,
    usb_packet_arbiter_if.master bus,
    input  logic                 clear_stats,
    output logic [AW:0]          fifo_level,
    output logic [15:0]          drop_count
);

    localparam logic [0:0]    ST_RUN     = 1'b0;
    localparam logic [0:0]    ST_DROP    = 1'b1;
    localparam int            SW         = $clog2(AUX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(AUX_STARVE);
    localparam logic [AW:0]   FULL_LVL   = (AW + 1)'(DEPTH);
    localparam logic [24:0]   MARKER     = {2'b11, 23'h7FFFFF};

    logic [24:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW:0]   count_r;
    logic [0:0]    state_r;
    logic [SW-1:0] starve_r;
    logic [15:0]   drop_r;
    logic          out_strobe_r;
    logic          aux_ack_r;
    logic [24:0]   out_data_r;

    logic          empty_s;
    logic          full_s;
    logic          trc_want_s;
    logic          mark_want_s;
    logic          want_s;
    logic [24:0]   want_data_s;
    logic [24:0]   head_s;
    logic          aux_elig_s;
    logic          force_s;
    logic          pop_s;
    logic          aux_gnt_s;
    logic          push_s;
    logic          drop_s;
    logic          bypass_s;

    // Grant, enqueue and overflow decisions for the current cycle.
    always_comb begin
        empty_s = (count_r == '0);
        full_s  = (count_r == FULL_LVL);
`ifdef OVERFLOW_MARKER_EN
        trc_want_s  = bus.trc_strobe && (state_r == ST_RUN);
        mark_want_s = (state_r == ST_DROP) && !bus.trc_strobe && !full_s;
`else
        trc_want_s  = bus.trc_strobe;
        mark_want_s = 1'b0;
`endif
        want_s      = trc_want_s || mark_want_s;
        want_data_s = mark_want_s ? MARKER : {bus.trc_type, bus.trc_payload};
        // An empty FIFO forwards the packet arriving this cycle so it can leave on the next one.
        head_s      = empty_s ? want_data_s : mem_r[rd_ptr_r];
        // The ack cycle still sees aux_req high, so the just-issued request is masked.
        aux_elig_s  = bus.aux_req && !aux_ack_r;
        force_s     = aux_elig_s && (starve_r == STARVE_LIM);
        pop_s       = bus.out_ready && (!empty_s || want_s) && !force_s;
        aux_gnt_s   = bus.out_ready && aux_elig_s && (force_s || (empty_s && !want_s));
        push_s      = want_s && (!full_s || pop_s);
        drop_s      = bus.trc_strobe && !(trc_want_s && push_s);
        bypass_s    = pop_s && empty_s;
    end

    // Trace FIFO storage; bypassed packets are never written.
    always_ff @(posedge mclk) begin
        if (push_s && !bypass_s) begin
            mem_r[wr_ptr_r] <= want_data_s;
        end
    end

    // Pointers, occupancy, overflow state, starvation guard, statistics and the output register.
    always_ff @(posedge mclk or posedge reset) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            count_r      <= '0;
            state_r      <= ST_RUN;
            starve_r     <= '0;
            drop_r       <= 16'h0000;
            out_strobe_r <= 1'b0;
            aux_ack_r    <= 1'b0;
            out_data_r   <= 25'd0;
        end else begin
            if (push_s && !bypass_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s && !bypass_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + (AW + 1)'(1);
                2'b01:   count_r <= count_r - (AW + 1)'(1);
                default: count_r <= count_r;
            endcase

            case (state_r)
                ST_RUN: begin
                    if (drop_s) state_r <= ST_DROP;
                end
                ST_DROP: begin
`ifdef OVERFLOW_MARKER_EN
                    if (mark_want_s && push_s) state_r <= ST_RUN;
`else
                    if (bus.trc_strobe && push_s) state_r <= ST_RUN;
`endif
                end
                default: state_r <= ST_RUN;
            endcase

            if (!aux_elig_s || aux_gnt_s) begin
                starve_r <= '0;
            end else if (pop_s && (starve_r != STARVE_LIM)) begin
                starve_r <= starve_r + SW'(1);
            end

            if (clear_stats) begin
                drop_r <= drop_s ? 16'h0001 : 16'h0000;
            end else if (drop_s && (drop_r != 16'hFFFF)) begin
                drop_r <= drop_r + 16'h0001;
            end

            out_strobe_r <= pop_s || aux_gnt_s;
            aux_ack_r    <= aux_gnt_s;
            if (pop_s) begin
                out_data_r <= head_s;
            end else if (aux_gnt_s) begin
                out_data_r <= {bus.aux_type, bus.aux_payload};
            end
        end
    end

    assign bus.out_strobe  = out_strobe_r;
    assign bus.aux_ack     = aux_ack_r;
    assign bus.out_type    = out_data_r[24:23];
    assign bus.out_payload = out_data_r[22:0];
    assign fifo_level      = count_r;
    assign drop_count      = drop_r;

endmodule

// File: tb/tb_usb_packet_arbiter.sv
// Directed bench for usb_packet_arbiter: a per-cycle vector table plus hand-written overflow,
// starvation, full push+pop, reset and counter-saturation sequences.
module tb_usb_packet_arbiter;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        mclk;
    logic        reset;
    logic        clear_stats;
    logic [AW:0] fifo_level;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    usb_packet_arbiter_if bus ();

    usb_packet_arbiter #(.DEPTH(DEPTH), .AW(AW), .AUX_STARVE(16)) dut (
        .mclk        (mclk),
        .reset       (reset),
        .bus         (bus.master),
        .clear_stats (clear_stats),
        .fifo_level  (fifo_level),
        .drop_count  (drop_count)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic        trc;
        logic [1:0]  ttype;
        logic [22:0] tpay;
        logic        areq;
        logic        rdy;
        logic        estb;
        logic [1:0]  etype;
        logic [22:0] epay;
        logic        eack;
        logic [4:0]  elvl;
    } vec_t;

    vec_t vecs [22];

    function automatic vec_t mk(input logic trc, input logic [1:0] tt, input logic [22:0] tp,
                                input logic areq, input logic rdy, input logic estb,
                                input logic [1:0] et, input logic [22:0] ep,
                                input logic eack, input logic [4:0] elvl);
        vec_t v;
        v.trc = trc; v.ttype = tt; v.tpay = tp; v.areq = areq; v.rdy = rdy;
        v.estb = estb; v.etype = et; v.epay = ep; v.eack = eack; v.elvl = elvl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.trc_strobe  = 1'b0;
        bus.trc_type    = 2'b00;
        bus.trc_payload = 23'd0;
        bus.aux_req     = 1'b0;
        bus.out_ready   = 1'b0;
        clear_stats     = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [24:0] got [$];
        logic [24:0] exp [$];
        int          trace_before_ack;
        int          ack_seen;

        bus.aux_type    = 2'b10;
        bus.aux_payload = 23'h123456;

        //            trc   tt     tpay    areq  rdy   estb  etype  epay        eack  elvl
        vecs[0]  = mk(1'b1, 2'd0, 23'd1, 1'b0, 1'b1, 1'b1, 2'd0, 23'd1,      1'b0, 5'd0);
        vecs[1]  = mk(1'b1, 2'd1, 23'd2, 1'b0, 1'b1, 1'b1, 2'd1, 23'd2,      1'b0, 5'd0);
        vecs[2]  = mk(1'b1, 2'd2, 23'd3, 1'b0, 1'b1, 1'b1, 2'd2, 23'd3,      1'b0, 5'd0);
        vecs[3]  = mk(1'b1, 2'd3, 23'd4, 1'b0, 1'b1, 1'b1, 2'd3, 23'd4,      1'b0, 5'd0);
        vecs[4]  = mk(1'b1, 2'd0, 23'd5, 1'b0, 1'b1, 1'b1, 2'd0, 23'd5,      1'b0, 5'd0);
        vecs[5]  = mk(1'b0, 2'd0, 23'd0, 1'b0, 1'b1, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);
        vecs[6]  = mk(1'b1, 2'd1, 23'd6, 1'b0, 1'b0, 1'b0, 2'd0, 23'd0,      1'b0, 5'd1);
        vecs[7]  = mk(1'b1, 2'd2, 23'd7, 1'b0, 1'b0, 1'b0, 2'd0, 23'd0,      1'b0, 5'd2);
        vecs[8]  = mk(1'b0, 2'd0, 23'd0, 1'b0, 1'b1, 1'b1, 2'd1, 23'd6,      1'b0, 5'd1);
        vecs[9]  = mk(1'b1, 2'd3, 23'd8, 1'b0, 1'b1, 1'b1, 2'd2, 23'd7,      1'b0, 5'd1);
        vecs[10] = mk(1'b0, 2'd0, 23'd0, 1'b0, 1'b1, 1'b1, 2'd3, 23'd8,      1'b0, 5'd0);
        vecs[11] = mk(1'b0, 2'd0, 23'd0, 1'b0, 1'b1, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);
        vecs[12] = mk(1'b0, 2'd0, 23'd0, 1'b1, 1'b0, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);
        vecs[13] = mk(1'b0, 2'd0, 23'd0, 1'b1, 1'b1, 1'b1, 2'd2, 23'h123456, 1'b1, 5'd0);
        vecs[14] = mk(1'b0, 2'd0, 23'd0, 1'b1, 1'b1, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);
        vecs[15] = mk(1'b0, 2'd0, 23'd0, 1'b0, 1'b0, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);
        vecs[16] = mk(1'b0, 2'd0, 23'd0, 1'b1, 1'b0, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);
        vecs[17] = mk(1'b0, 2'd0, 23'd0, 1'b1, 1'b1, 1'b1, 2'd2, 23'h123456, 1'b1, 5'd0);
        vecs[18] = mk(1'b0, 2'd0, 23'd0, 1'b0, 1'b0, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);
        vecs[19] = mk(1'b1, 2'd1, 23'd9, 1'b1, 1'b1, 1'b1, 2'd1, 23'd9,      1'b0, 5'd0);
        vecs[20] = mk(1'b0, 2'd0, 23'd0, 1'b1, 1'b1, 1'b1, 2'd2, 23'h123456, 1'b1, 5'd0);
        vecs[21] = mk(1'b0, 2'd0, 23'd0, 1'b0, 1'b1, 1'b0, 2'd0, 23'd0,      1'b0, 5'd0);

        // Reset state
        do_reset();
        chk("rst_level",   32'(fifo_level),      32'd0);
        chk("rst_drop",    32'(drop_count),      32'd0);
        chk("rst_strobe",  32'(bus.out_strobe),  32'd0);
        chk("rst_ack",     32'(bus.aux_ack),     32'd0);
        chk("rst_type",    32'(bus.out_type),    32'd0);
        chk("rst_payload", 32'(bus.out_payload), 32'd0);

        // Table-driven per-cycle vectors: in-order trace, buffering, aux grants, priority
        for (int i = 0; i < 22; i++) begin
            bus.trc_strobe  = vecs[i].trc;
            bus.trc_type    = vecs[i].ttype;
            bus.trc_payload = vecs[i].tpay;
            bus.aux_req     = vecs[i].areq;
            bus.out_ready   = vecs[i].rdy;
            tick();
            chk($sformatf("v%0d_strobe", i), 32'(bus.out_strobe), 32'(vecs[i].estb));
            chk($sformatf("v%0d_ack", i),    32'(bus.aux_ack),    32'(vecs[i].eack));
            chk($sformatf("v%0d_level", i),  32'(fifo_level),     32'(vecs[i].elvl));
            if (vecs[i].estb) begin
                chk($sformatf("v%0d_type", i),    32'(bus.out_type),    32'(vecs[i].etype));
                chk($sformatf("v%0d_payload", i), 32'(bus.out_payload), 32'(vecs[i].epay));
            end
        end

        // Overflow: DEPTH+3 strobes with the port stalled, then drain
        do_reset();
        for (int i = 0; i < DEPTH + 3; i++) begin
            bus.trc_strobe  = 1'b1;
            bus.trc_type    = i[1:0];
            bus.trc_payload = 23'(i);
            tick();
        end
        bus.trc_strobe = 1'b0;
        chk("ovf_level", 32'(fifo_level), 32'(DEPTH));
        chk("ovf_drop",  32'(drop_count), 32'd3);
        got.delete();
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (bus.out_strobe) got.push_back({bus.out_type, bus.out_payload});
        end
        bus.trc_strobe  = 1'b1;
        bus.trc_type    = 2'b01;
        bus.trc_payload = 23'h55;
        tick();
        if (bus.out_strobe) got.push_back({bus.out_type, bus.out_payload});
        bus.trc_strobe = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (bus.out_strobe) got.push_back({bus.out_type, bus.out_payload});
        end
        exp.delete();
        for (int i = 0; i < DEPTH; i++) exp.push_back({i[1:0], 23'(i)});
`ifdef OVERFLOW_MARKER_EN
        exp.push_back({2'b11, 23'h7FFFFF});
`endif
        exp.push_back({2'b01, 23'h55});
        chk("ovf_pkt_count", 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("ovf_pkt%0d", i), 32'(got[i]), 32'(exp[i]));
        end
        chk("ovf_drop_after", 32'(drop_count), 32'd3);

        // Starvation guard: aux held against continuous trace traffic
        do_reset();
        bus.aux_type    = 2'b11;
        bus.aux_payload = 23'h0ABCDE;
        bus.aux_req     = 1'b1;
        bus.out_ready   = 1'b1;
        trace_before_ack = 0;
        ack_seen         = 0;
        for (int k = 0; k < 40 && ack_seen == 0; k++) begin
            bus.trc_strobe  = 1'b1;
            bus.trc_type    = 2'b01;
            bus.trc_payload = 23'(k);
            tick();
            if (bus.aux_ack) begin
                ack_seen = 1;
                chk("starve_aux_strobe",  32'(bus.out_strobe),  32'd1);
                chk("starve_aux_type",    32'(bus.out_type),    32'd3);
                chk("starve_aux_payload", 32'(bus.out_payload), 32'h0ABCDE);
            end else if (bus.out_strobe) begin
                trace_before_ack++;
            end
        end
        chk("starve_ack_seen",  32'(ack_seen),         32'd1);
        chk("starve_trace_cnt", 32'(trace_before_ack), 32'd16);
        bus.aux_req     = 1'b0;
        bus.trc_payload = 23'd17;
        tick();
        chk("starve_resume_strobe",  32'(bus.out_strobe),  32'd1);
        chk("starve_resume_payload", 32'(bus.out_payload), 32'd16);
        chk("starve_resume_ack",     32'(bus.aux_ack),     32'd0);
        bus.trc_strobe = 1'b0;
        bus.aux_type    = 2'b10;
        bus.aux_payload = 23'h123456;

        // Full FIFO with simultaneous push and pop
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            bus.trc_strobe  = 1'b1;
            bus.trc_payload = 23'(100 + i);
            tick();
        end
        chk("full_level", 32'(fifo_level), 32'(DEPTH));
        bus.trc_payload = 23'd200;
        bus.out_ready   = 1'b1;
        tick();
        chk("full_pp_level",   32'(fifo_level),      32'(DEPTH));
        chk("full_pp_drop",    32'(drop_count),      32'd0);
        chk("full_pp_strobe",  32'(bus.out_strobe),  32'd1);
        chk("full_pp_payload", 32'(bus.out_payload), 32'd100);
        idle_inputs();

        // Asynchronous reset with 7 packets queued
        do_reset();
        for (int i = 0; i < 7; i++) begin
            bus.trc_strobe  = 1'b1;
            bus.trc_payload = 23'(i);
            tick();
        end
        bus.trc_strobe = 1'b0;
        chk("mid_level_before", 32'(fifo_level), 32'd7);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_level_async",  32'(fifo_level),     32'd0);
        chk("mid_strobe_async", 32'(bus.out_strobe), 32'd0);
        tick();
        reset = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("mid_level_after",  32'(fifo_level),     32'd0);
        chk("mid_strobe_after", 32'(bus.out_strobe), 32'd0);

        // drop_count saturation and clear_stats
        do_reset();
        bus.trc_strobe = 1'b1;
        for (int i = 0; i < DEPTH + 65540; i++) tick();
        chk("sat_drop", 32'(drop_count), 32'hFFFF);
        bus.trc_strobe = 1'b0;
        clear_stats    = 1'b1;
        tick();
        chk("clr_drop", 32'(drop_count), 32'd0);
        bus.trc_strobe = 1'b1;
        tick();
        chk("clr_with_drop", 32'(drop_count), 32'd1);
        idle_inputs();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
